// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: one result bit per cycle, shift-add multiply
// or restoring divide, finishing with one combined HiLo write.
module mdu_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              flush,
  output logic              stallReq,
  output logic              busy,
  output logic [DATA_W-1:0] wHiData,
  output logic [DATA_W-1:0] wLoData,
  output logic              whi,
  output logic              wlo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0]   ONE      = DATA_W'(1);
  localparam logic [2*DATA_W-1:0] ONE2     = (2*DATA_W)'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  busy_q, busy_d;

  logic                  is_div;
  logic                  is_signed;
  logic                  sign_a;
  logic                  sign_b;
  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;
  logic [DATA_W:0]       mul_sum;
  logic [2*DATA_W-1:0]   mul_next;
  logic [DATA_W:0]       rem_sh;
  logic [DATA_W-1:0]     quo_sh;
  logic                  no_borrow;
  logic [DATA_W-1:0]     div_diff;
  logic [2*DATA_W-1:0]   div_next;
  logic [2*DATA_W-1:0]   prod_neg;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign sign_a    = is_signed & a_q[DATA_W-1];
  assign sign_b    = is_signed & b_q[DATA_W-1];
  assign mag_a     = sign_a ? (~a_q + ONE) : a_q;
  assign mag_b     = sign_b ? (~b_q + ONE) : b_q;

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {rem, quo}; the shifted remainder needs one extra bit before the trial.
  assign rem_sh    = acc_q[2*DATA_W-1:DATA_W-1];
  assign quo_sh    = {acc_q[DATA_W-2:0], 1'b0};
  assign no_borrow = (rem_sh >= {1'b0, b_q});
  assign div_diff  = rem_sh[DATA_W-1:0] - b_q;
  assign div_next  = no_borrow ? {div_diff, quo_sh[DATA_W-1:1], 1'b1}
                               : {rem_sh[DATA_W-1:0], quo_sh};

  assign prod_neg = ~acc_q + ONE2;
  assign quo_fix  = neg_res_q ? (~acc_q[DATA_W-1:0] + ONE) : acc_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + ONE)
                              : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          if (is_div && (b_q == '0)) begin
            hi_d    = a_q;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            a_d     = mag_a;
            b_d     = mag_b;
            cnt_d   = '0;
            acc_d   = is_div ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // Results go straight into the output registers so they hold until the next DONE.
          if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else if (neg_res_q) begin
            hi_d = prod_neg[2*DATA_W-1:DATA_W];
            lo_d = prod_neg[DATA_W-1:0];
          end else begin
            hi_d = acc_q[2*DATA_W-1:DATA_W];
            lo_d = acc_q[DATA_W-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  // Stall drops in DONE so the following instruction advances as the write lands.
  assign stallReq = ((state_q == S_IDLE) & start & ~flush) |
                    (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX);
  assign whi      = (state_q == S_DONE) & ~flush;
  assign wlo      = whi;
  assign busy     = busy_q;
  assign wHiData  = hi_q;
  assign wLoData  = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table plus random ops against a scoreboard of expected
// HiLo writes, with hand sequences for flush, busy restart and async reset.
module tb_mdu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        stallReq;
  logic        busy;
  logic [31:0] wHiData;
  logic [31:0] wLoData;
  logic        whi;
  logic        wlo;

  mdu_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .flush    (flush),
    .stallReq (stallReq),
    .busy     (busy),
    .wHiData  (wHiData),
    .wLoData  (wLoData),
    .whi      (whi),
    .wlo      (wlo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (whi || wlo) begin
      exp_t e;
      chk("wlo_eq_whi", {63'd0, wlo}, {63'd0, whi});
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: hi=%h lo=%h at cycle %0d", wHiData, wLoData, cyc);
      end else begin
        e = sb.pop_front();
        chk("write_hi", {32'd0, wHiData}, {32'd0, e.hi});
        chk("write_lo", {32'd0, wLoData}, {32'd0, e.lo});
        chk("write_latency", 64'(cyc - e.t0), 64'(e.lat));
        $display("write: hi=%h lo=%h latency=%0d", wHiData, wLoData, cyc - e.t0);
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ua, ub, r;
    longint      sa, sb_l, q, rm;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb_l = longint'($signed(b));
    r = '0;
    case (mop)
      2'b00: r = ua * ub;
      2'b01: r = 64'(sa * sb_l);
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb_l;
          rm = sa % sb_l;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] hi, input logic [31:0] lo,
                       input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    if (push) begin
      e.hi  = hi;
      e.lo  = lo;
      e.t0  = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: pending=%0d busy=%b", sb.size(), busy);
      sb.delete();
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        34};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[5] = '{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
    vecs[7] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34};
    vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};

    cyc = 0; checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, stallReq}, 64'd0);
    chk("reset_whi", {63'd0, whi}, 64'd0);
    chk("reset_hi", {32'd0, wHiData}, 64'd0);
    chk("reset_lo", {32'd0, wLoData}, 64'd0);
    rst = 1'b1;

    // MULTU with stall/busy profile across the whole operation.
    @(negedge clk);
    start = 1'b1; op = vecs[0].op; opA = vecs[0].a; opB = vecs[0].b;
    #1;
    chk("stall_on_start", {63'd0, stallReq}, 64'd1);
    sb.push_back('{vecs[0].hi, vecs[0].lo, cyc + 1, vecs[0].lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", k), {63'd0, stallReq}, (k <= 33) ? 64'd1 : 64'd0);
      chk($sformatf("busy_c%0d", k), {63'd0, busy}, 64'd1);
    end
    wait_idle();

    for (int i = 1; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo, vecs[i].lat);
      wait_idle();
    end

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 4 == 0) rb = 32'($urandom_range(1, 20));
      m = model(ro, ra, rb);
      issue(ro, ra, rb, 1'b1, m[63:32], m[31:0], (ro[1] && rb == 32'd0) ? 1 : 34);
      wait_idle();
    end

    // start re-pulsed while busy must be ignored.
    issue(2'b10, 32'd1000, 32'd3, 1'b1, 32'd1, 32'd333, 34);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; opA = 32'd5; opB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // flush in CALC at counter 10: abort with no write.
    issue(2'b00, 32'd123, 32'd456, 1'b0, '0, '0, 0);
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_calc_busy", {63'd0, busy}, 64'd0);
    chk("flush_calc_stall", {63'd0, stallReq}, 64'd0);
    repeat (40) @(negedge clk);

    // flush together with start in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1 chk("flush_start_stall", {63'd0, stallReq}, 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);

    issue(2'b00, 32'd123, 32'd456, 1'b1, 32'd0, 32'd56088, 34);
    wait_idle();

    // flush during DONE gates the write pulse.
    issue(2'b10, 32'd50, 32'd5, 1'b0, '0, '0, 0);
    repeat (34) @(posedge clk);
    #1;
    chk("done_whi_before_flush", {63'd0, whi}, 64'd1);
    flush = 1'b1;
    #1 chk("done_whi_flushed", {63'd0, whi}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("done_flush_busy", {63'd0, busy}, 64'd0);

    // Async reset mid-CALC.
    issue(2'b01, 32'h0000_7777, 32'hFFFF_0001, 1'b0, '0, '0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_stall", {63'd0, stallReq}, 64'd0);
    chk("arst_whi", {63'd0, whi}, 64'd0);
    chk("arst_wlo", {63'd0, wlo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (45) @(negedge clk);
    chk("arst_hi", {32'd0, wHiData}, 64'd0);
    chk("arst_lo", {32'd0, wLoData}, 64'd0);

    issue(2'b11, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 34);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
